// File: rtl/addr_gen_out_tiled_if.sv
// addr_gen_out_tiled_if: tile request/status handshake and per-bank write bus of addr_gen_out_tiled.
interface addr_gen_out_tiled_if #(
  parameter int RAM_O_SIZE = 256,
  parameter int ARRAY_M = 8,
  parameter int ROW_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(RAM_O_SIZE),
  parameter int ADDR_SET_WIDTH = ADDR_WIDTH * ARRAY_M
);
  logic                      start;
  logic [ROW_WIDTH-1:0]      num_rows;
  logic [$clog2(ARRAY_M):0]  num_cols;
  logic [ADDR_WIDTH-1:0]     base_addr;
  logic [ADDR_WIDTH-1:0]     row_stride;
  logic                      busy;
  logic                      done;
  logic [ADDR_SET_WIDTH-1:0] addr_set;
  logic [ARRAY_M-1:0]        enable_set;
  modport master (
    output start, num_rows, num_cols, base_addr, row_stride,
    input  busy, done, addr_set, enable_set
  );
  modport slave (
    input  start, num_rows, num_cols, base_addr, row_stride,
    output busy, done, addr_set, enable_set
  );
endinterface

// File: rtl/addr_gen_out_tiled.sv
// addr_gen_out_tiled: output-bank write address/enable generator for one tile per start pulse.
// OUT_ADDR_SKEW_EN defined: column m lags column 0 by m cycles; undefined: all columns write together.
module addr_gen_out_tiled #(
  parameter int RAM_O_SIZE = 256,
  parameter int ARRAY_M = 8,
  parameter int ROW_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(RAM_O_SIZE),
  parameter int ADDR_SET_WIDTH = ADDR_WIDTH * ARRAY_M
) (
  input logic clk,
  input logic reset,
  addr_gen_out_tiled_if.slave tile_if
);
  localparam int CW = $clog2(ARRAY_M) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  state_e                state_q, state_d;
  logic [ROW_WIDTH-1:0]  rows_left_q, rows_left_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic                  en0_q, en0_d;
  logic [ARRAY_M-1:0]    mask_q, mask_d;
  logic [CW-1:0]         clamp;
  logic                  accept, go;
  logic [ADDR_SET_WIDTH-1:0] addr_set;
  logic [ARRAY_M-1:0]    enable_set;
`ifdef OUT_ADDR_SKEW_EN
  logic [CW-1:0]         drain_q, drain_d;
  logic [ARRAY_M-1:1]    tail_en_q;
  logic [ADDR_WIDTH-1:0] tail_addr_q [1:ARRAY_M-1];
  logic [ARRAY_M-1:0]    col_en;
  logic [ADDR_WIDTH-1:0] col_addr [ARRAY_M];
`endif
  assign clamp  = tile_if.num_cols > CW'(ARRAY_M) ? CW'(ARRAY_M) : tile_if.num_cols;
  assign accept = tile_if.start && (state_q == IDLE || state_q == DONE);
  assign go     = accept && tile_if.num_rows != '0 && clamp != '0;
  always_comb begin
    state_d = state_q;
    rows_left_d = rows_left_q;
    stride_d = stride_q;
    mask_d = mask_q;
    en0_d = 1'b0;
    addr0_d = addr0_q;
`ifdef OUT_ADDR_SKEW_EN
    drain_d = drain_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        state_d = accept ? (go ? RUN : DONE) : IDLE;
        if (accept) begin
          rows_left_d = tile_if.num_rows - 1'b1;
          stride_d = tile_if.row_stride;
          addr0_d = tile_if.base_addr;
          en0_d = go;
          for (int m = 0; m < ARRAY_M; m++) mask_d[m] = CW'(m) < clamp;
`ifdef OUT_ADDR_SKEW_EN
          drain_d = clamp - CW'(2);
`endif
        end
      end
      RUN: begin
        en0_d = rows_left_q != '0;
        addr0_d = rows_left_q != '0 ? addr0_q + stride_q : addr0_q;
        rows_left_d = rows_left_q - 1'b1;
`ifdef OUT_ADDR_SKEW_EN
        state_d = rows_left_q != '0 ? RUN : (mask_q[1] ? DRAIN : DONE);
`else
        state_d = rows_left_q != '0 ? RUN : DONE;
`endif
      end
      default: begin
`ifdef OUT_ADDR_SKEW_EN
        // drain_q counts the remaining skew-tail cycles after this one
        state_d = drain_q == '0 ? DONE : DRAIN;
        drain_d = drain_q - 1'b1;
`else
        state_d = DONE;
`endif
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rows_left_q <= '0;
      stride_q <= '0;
      addr0_q <= '0;
      en0_q <= 1'b0;
      mask_q <= '0;
`ifdef OUT_ADDR_SKEW_EN
      drain_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rows_left_q <= rows_left_d;
      stride_q <= stride_d;
      addr0_q <= addr0_d;
      en0_q <= en0_d;
      mask_q <= mask_d;
`ifdef OUT_ADDR_SKEW_EN
      drain_q <= drain_d;
`endif
    end
  end
`ifdef OUT_ADDR_SKEW_EN
  always_comb begin
    col_en = {tail_en_q, en0_q};
    col_addr[0] = addr0_q;
    for (int m = 1; m < ARRAY_M; m++) col_addr[m] = tail_addr_q[m];
  end
  // each active column replays its left neighbour one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      tail_en_q <= '0;
      for (int m = 1; m < ARRAY_M; m++) tail_addr_q[m] <= '0;
    end else begin
      for (int m = 1; m < ARRAY_M; m++) begin
        tail_en_q[m] <= col_en[m-1] & mask_q[m];
        tail_addr_q[m] <= mask_q[m] ? col_addr[m-1] : '0;
      end
    end
  end
`endif
  always_comb begin
    addr_set = '0;
    enable_set = '0;
    for (int m = 0; m < ARRAY_M; m++) begin
`ifdef OUT_ADDR_SKEW_EN
      enable_set[m] = col_en[m] & mask_q[m];
      addr_set[ADDR_WIDTH*m +: ADDR_WIDTH] = mask_q[m] ? col_addr[m] : '0;
`else
      enable_set[m] = en0_q & mask_q[m];
      addr_set[ADDR_WIDTH*m +: ADDR_WIDTH] = mask_q[m] ? addr0_q : '0;
`endif
    end
  end
  assign tile_if.busy = state_q == RUN || state_q == DRAIN;
  assign tile_if.done = state_q == DONE;
  assign tile_if.addr_set = addr_set;
  assign tile_if.enable_set = enable_set;
endmodule

// File: tb/tb_addr_gen_out_tiled.sv
// tb_addr_gen_out_tiled: scoreboard bench; a tile model queues expected writes, a monitor checks each cycle.
module tb_addr_gen_out_tiled;
  localparam int M = 8, AW = 8, RW = 8, CW = 4;
`ifdef OUT_ADDR_SKEW_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif
  typedef struct { int c; logic [AW-1:0] a; } ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0, checks = 0, failures = 0, free_from = 0;
  ev_t colq [M][$];
  int doneq [$];
  bit exp_busy [int];
  addr_gen_out_tiled_if #(.RAM_O_SIZE(256), .ARRAY_M(M), .ROW_WIDTH(RW)) bus ();
  addr_gen_out_tiled #(.RAM_O_SIZE(256), .ARRAY_M(M), .ROW_WIDTH(RW)) dut (
    .clk(clk), .reset(reset), .tile_if(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Tile accepted with start high in cycle n: row r lands in cycle n+1+r (+m when skewed).
  function automatic void model(int n, int rows, int cols, int base, int stride);
    int k = cols > M ? M : cols;
    int span = SKEW ? rows + k : rows + 1;
    ev_t e;
    if (rows == 0 || k == 0) begin
      doneq.push_back(n + 1);
      free_from = n + 1;
      return;
    end
    for (int m = 0; m < k; m++)
      for (int r = 0; r < rows; r++) begin
        e.c = n + 1 + r + SKEW * m;
        e.a = AW'(base + r * stride);
        colq[m].push_back(e);
      end
    for (int c = n + 1; c < n + span; c++) exp_busy[c] = 1'b1;
    doneq.push_back(n + span);
    free_from = n + span;
  endfunction
  function automatic void flush(int n);
    for (int m = 0; m < M; m++)
      while (colq[m].size() > 0 && colq[m][colq[m].size()-1].c > n) void'(colq[m].pop_back());
    while (doneq.size() > 0 && doneq[doneq.size()-1] > n) void'(doneq.pop_back());
    for (int c = n + 1; c < n + 64; c++) exp_busy.delete(c);
    free_from = n + 1;
  endfunction
  task automatic step(bit st, int rows, int cols, int base, int stride, bit rst);
    @(negedge clk);
    bus.start = st;
    bus.num_rows = RW'(rows);
    bus.num_cols = CW'(cols);
    bus.base_addr = AW'(base);
    bus.row_stride = AW'(stride);
    reset = rst;
    if (rst) flush(cyc);
    else if (st && cyc >= free_from) model(cyc, rows, cols, base, stride);
  endtask
  task automatic idle(int k);
    for (int i = 0; i < k; i++)
      step(1'b0, $urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255), 1'b0);
  endtask
  always @(negedge clk) begin
    ev_t e;
    logic [AW-1:0] a;
    bit exp_en, exp_done, exp_b;
    if (cyc > 0) begin
      for (int m = 0; m < M; m++) begin
        a = bus.addr_set[m*AW +: AW];
        exp_en = colq[m].size() > 0 && colq[m][0].c == cyc;
        checks++;
        if (bus.enable_set[m] !== exp_en) begin
          failures++;
          $display("FAIL enable col%0d cyc=%0d got=%b want=%b", m, cyc, bus.enable_set[m], exp_en);
        end
        if (exp_en) begin
          e = colq[m].pop_front();
          if (bus.enable_set[m] === 1'b1) begin
            checks++;
            if (a !== e.a) begin
              failures++;
              $display("FAIL addr col%0d cyc=%0d got=%h want=%h", m, cyc, a, e.a);
            end
          end
        end
      end
      exp_done = doneq.size() > 0 && doneq[0] == cyc;
      if (exp_done) void'(doneq.pop_front());
      checks++;
      if (bus.done !== exp_done) begin
        failures++;
        $display("FAIL done cyc=%0d got=%b want=%b", cyc, bus.done, exp_done);
      end
      exp_b = exp_busy.exists(cyc);
      exp_busy.delete(cyc);
      checks++;
      if (bus.busy !== exp_b) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, bus.busy, exp_b);
      end
    end
  end
  initial begin
    int left;
    bit rst, st;
    bus.start = 1'b0;
    bus.num_rows = '0;
    bus.num_cols = '0;
    bus.base_addr = '0;
    bus.row_stride = '0;
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 0, 1'b1);
    idle(2);
    step(1'b1, 4, 8, 'h10, 1, 1'b0);
    idle(14);
    step(1'b1, 3, 3, 'h00, 8, 1'b0);
    idle(8);
    step(1'b1, 4, 8, 'hFE, 1, 1'b0);
    idle(14);
    step(1'b1, 4, 2, 'h20, 3, 1'b0);
    idle(2);
    step(1'b1, 6, 8, 'h40, 5, 1'b0);
    while (cyc + 1 < free_from) idle(1);
    step(1'b1, 3, 5, 'h80, 7, 1'b0);
    idle(10);
    step(1'b1, 0, 5, 'h11, 1, 1'b0);
    idle(3);
    step(1'b1, 5, 0, 'h11, 1, 1'b0);
    step(1'b1, 2, 4, 'h33, 2, 1'b0);
    idle(8);
    step(1'b1, 3, 15, 'hA0, 9, 1'b0);
    idle(14);
    step(1'b1, 8, 8, 'h00, 4, 1'b0);
    idle(1);
    step(1'b0, 0, 0, 0, 0, 1'b1);
    idle(3);
    step(1'b1, 2, 2, 'h55, 1, 1'b0);
    idle(6);
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 79) == 0;
      st = !rst && $urandom_range(0, 3) == 0;
      step(st, $urandom_range(0, 12), $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255), rst);
    end
    idle(40);
    left = doneq.size();
    for (int m = 0; m < M; m++) left += colq[m].size();
    checks++;
    if (left != 0) begin
      failures++;
      $display("FAIL drained leftover_expectations=%0d want=0", left);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/addr_gen_out_tiled.md
Name: addr_gen_out_tiled

Overview:
- Generates per-column write addresses and enables for the output RAM banks of the ARRAY_M-column systolic array.
- One start pulse produces one output tile of num_rows rows over num_cols columns, with a programmable row stride.
- Column m's writes are skewed by m cycles, matching the diagonal drain of the array.
- Start/busy/done handshake to the tile controller.

Parameters:
- RAM_O_SIZE, 256, depth of each output RAM bank.
- ARRAY_M, 8, number of array columns / output banks.
- ROW_WIDTH, 8, width of num_rows (max tile rows 2^ROW_WIDTH-1).
- ADDR_WIDTH, $clog2(RAM_O_SIZE), bank address width.
- ADDR_SET_WIDTH, ADDR_WIDTH*ARRAY_M, flattened address bus width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle tile start request
- num_rows  in  ROW_WIDTH  rows in tile
- num_cols  in  $clog2(ARRAY_M)+1  active columns
- base_addr  in  ADDR_WIDTH  address of row 0
- row_stride  in  ADDR_WIDTH  address increment per row
- busy  out  1  tile in progress
- done  out  1  one-cycle completion pulse
- addr_set  out  ADDR_SET_WIDTH  column m address at [ADDR_WIDTH*m +: ADDR_WIDTH]
- enable_set  out  ARRAY_M  column m write enable at bit m

Behaviour:
- Clock and reset: clk, reset (synchronous, active-high). Reset values: busy=0, done=0, enable_set=0, addr_set=0; all internal counters and pipelines are cleared.
- start is accepted at edge T only when busy=0. At that edge, num_rows, num_cols, base_addr and row_stride are latched. Input changes after T are ignored for the rest of the tile. start while busy=1 is ignored.
- num_cols > ARRAY_M is clamped to ARRAY_M.
- Row address: addr(r) = base_addr + r*row_stride, modulo 2^ADDR_WIDTH (wraps silently). Compute it incrementally by adding row_stride each row; no multiplier.
- Column 0: enable high in cycles T+1 .. T+num_rows, with address addr(r) in cycle T+1+r.
- Column m < num_cols: carries exactly column 0's (enable, address) sequence delayed by m cycles. Implement as a per-column register chain.
- Columns m >= num_cols: enable held 0, address held 0.
- addr_set bits are don't-care when the corresponding enable is 0. The bench checks addresses only where enable=1.
- FSM:
  - IDLE --accepted start, rows>0 and cols>0--> RUN.
  - RUN: column 0 issues rows. After the last row issues --> DRAIN.
  - DRAIN: waits for the skew tail to empty --> DONE.
  - DONE: one cycle, done=1 --> IDLE.
- busy=1 from T+1 through the last enabled cycle, T+num_rows+num_cols-1. busy=0 in the done cycle.
- done=1 only in cycle T+num_rows+num_cols.
- Back-to-back: a start in the done cycle is accepted. The next tile's first enable follows in the next cycle, with no bubble beyond that.
- Degenerate tile (num_rows=0 or num_cols=0): no enables, busy stays 0, done pulses at T+1.
- Reset mid-tile: at the next edge all outputs return to their reset values, no done is generated, and the FSM returns to IDLE.

Optional Feature:
- Macro: OUT_ADDR_SKEW_EN.
- Defined: per-column m-cycle skew as described above. Done at T+num_rows+num_cols.
- Undefined:
  - All active columns enable simultaneously in T+1 .. T+num_rows with identical addresses.
  - The DRAIN state is bypassed. done=1 at T+num_rows+1, and busy=0 in that cycle.

Test Plan:
- Skew on, base=0x10, stride=1, rows=4, cols=8, start at T:
  - col0 enables T+1..T+4 with addresses 0x10..0x13.
  - col7 enables T+8..T+11 with the same addresses.
  - done at T+12.
- Partial columns and stride: rows=3, cols=3, base=0x00, stride=8:
  - cols 0-2 addresses 0x00, 0x08, 0x10, skewed by 0/1/2 cycles.
  - enable_set[7:3]=0 throughout.
  - done at T+6.
- Wrap-around: base=0xFE, stride=1, rows=4 → column addresses 0xFE, 0xFF, 0x00, 0x01.
- Handshake:
  - start pulsed again at T+3 of a rows=4/cols=2 tile → ignored, no extra enables.
  - start in the done cycle → second tile begins the next cycle.
- Degenerate and clamp:
  - rows=0 → done at T+1, busy never high, enable_set=0.
  - cols=15 (ARRAY_M=8) behaves as cols=8.
- Reset at T+2 of a rows=8/cols=8 tile → from T+3 enable_set=0, busy=0, no done pulse. A new start is accepted normally afterwards.
- Skew macro off, rows=4, cols=8 → all 8 enables high T+1..T+4, done at T+5.
